// File: rtl/survivor_path_store_pkg.sv
// survivor_path_store_pkg: shared sizes and FSM state type for the survivor path store
package survivor_path_store_pkg;
  localparam int word_num = 16;
  localparam int word_num_bit = 4;
  localparam int POS_num = 11;
  localparam int POS_num_bit = 4;
  localparam logic [word_num_bit-1:0] last_word = word_num_bit'(word_num - 1);
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
endpackage

// File: rtl/survivor_path_store_bp_regfile.sv
// survivor_path_store_bp_regfile: backpointer storage, one sync write port, one async field-select read port
module survivor_path_store_bp_regfile
  import survivor_path_store_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           we,
  input  logic [word_num_bit-1:0]        wa,
  input  logic [POS_num*POS_num_bit-1:0] wd,
  input  logic [word_num_bit-1:0]        ra,
  input  logic [POS_num_bit-1:0]         rs,
  output logic [POS_num_bit-1:0]         rd
);
  logic [POS_num*POS_num_bit-1:0] mem [word_num];
  logic [POS_num_bit-1:0] fld [POS_num];
  // whole-vector write; storage cleared only by reset
  always_ff @(posedge clk or negedge reset)
    if (!reset)
      for (int i = 0; i < word_num; i++) mem[i] <= '0;
    else if (we)
      mem[wa] <= wd;
  // split the addressed word into fields, out-of-range state reads as zero
  always_comb begin
    for (int i = 0; i < POS_num; i++) fld[i] = mem[ra][i*POS_num_bit +: POS_num_bit];
    rd = (rs < POS_num_bit'(POS_num)) ? fld[rs] : '0;
  end
endmodule

// File: rtl/survivor_path_store.sv
// survivor_path_store: writes per-word backpointer vectors and hands the last index to traceback
module survivor_path_store
  import survivor_path_store_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           bp_valid,
  output logic                           bp_ready,
  input  logic [POS_num*POS_num_bit-1:0] bp_data,
  input  logic                           bp_last,
  output logic [word_num_bit-1:0]        wr_ptr,
  output logic                           done,
  output logic [word_num_bit-1:0]        key_out,
  output logic                           overflow,
  input  logic [word_num_bit-1:0]        rd_word,
  input  logic [POS_num_bit-1:0]         rd_state,
  output logic [POS_num_bit-1:0]         rd_bp
);
  state_t state, state_nxt;
  logic hs, full;
  logic [POS_num_bit-1:0] raw_bp;
  assign hs = bp_valid && bp_ready;
  assign full = wr_ptr == last_word;
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  // next state: start wins over any handshake, sentence ends on bp_last or a full store
  always_comb
    state_nxt = start ? FILL :
                (state == FILL && hs && (bp_last || full)) ? DONE : state;
  // outputs decoded from state
  always_comb bp_ready = state == FILL;
  // pointer, key and flags; the pointer saturates instead of wrapping
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      key_out <= '0;
      done <= 1'b0;
      overflow <= 1'b0;
    end else if (start) begin
      wr_ptr <= '0;
      done <= 1'b0;
      overflow <= 1'b0;
    end else if (hs) begin
      if (bp_last || full) begin
        key_out <= wr_ptr;
        done <= 1'b1;
        overflow <= !bp_last;
      end else
        wr_ptr <= wr_ptr + 1'b1;
    end
  survivor_path_store_bp_regfile u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (hs && !start),
    .wa    (wr_ptr),
    .wd    (bp_data),
    .ra    (rd_word),
    .rs    (rd_state),
    .rd    (raw_bp)
  );
  // words beyond the finished sentence are stale and read as zero
  always_comb rd_bp = (done && rd_word > key_out) ? '0 : raw_bp;
endmodule

// File: tb/tb_survivor_path_store.sv
// tb_survivor_path_store: scenario tasks with a read-back scoreboard for survivor_path_store
module tb_survivor_path_store;
  import survivor_path_store_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic bp_valid = 1'b0;
  logic bp_ready;
  logic [POS_num*POS_num_bit-1:0] bp_data = '0;
  logic bp_last = 1'b0;
  logic [word_num_bit-1:0] wr_ptr, key_out;
  logic done, overflow;
  logic [word_num_bit-1:0] rd_word = '0;
  logic [POS_num_bit-1:0] rd_state = '0;
  logic [POS_num_bit-1:0] rd_bp;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [3:0] w;
    logic [3:0] s;
    logic [3:0] v;
  } sb_t;
  sb_t sb [$];

  survivor_path_store dut (
    .clk(clk), .reset(reset), .start(start), .bp_valid(bp_valid), .bp_ready(bp_ready),
    .bp_data(bp_data), .bp_last(bp_last), .wr_ptr(wr_ptr), .done(done), .key_out(key_out),
    .overflow(overflow), .rd_word(rd_word), .rd_state(rd_state), .rd_bp(rd_bp)
  );

  always #5 clk = ~clk;

  function automatic logic [POS_num*POS_num_bit-1:0] vec(input int k);
    logic [POS_num*POS_num_bit-1:0] v;
    v = '0;
    for (int s = 0; s < POS_num; s++) v[s*POS_num_bit +: POS_num_bit] = 4'((k + s) % POS_num);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input int k, input logic last);
    bp_valid = 1'b1;
    bp_data = vec(k);
    bp_last = last;
    tick();
    bp_valid = 1'b0;
    bp_last = 1'b0;
  endtask

  task automatic push(input int w, input int s, input int v);
    sb_t e;
    e.w = 4'(w);
    e.s = 4'(s);
    e.v = 4'(v);
    sb.push_back(e);
  endtask

  task automatic drain(input string tag);
    sb_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd_word = e.w;
      rd_state = e.s;
      #1;
      checks++;
      if (rd_bp !== e.v) begin
        errors++;
        $display("FAIL %s rd_bp[%0d][%0d] got %0d expected %0d", tag, e.w, e.s, rd_bp, e.v);
      end
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (wr_ptr !== 4'd0 || done !== 1'b0 || key_out !== 4'd0 || overflow !== 1'b0 || bp_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got wr_ptr=%0d done=%b key=%0d ovf=%b rdy=%b expected 0 0 0 0 0", wr_ptr, done, key_out, overflow, bp_ready);
    end
    tick();
    reset = 1'b1;
    tick();
    do_start();
    for (int k = 0; k < 3; k++) send(k + 1, 1'b0);
    checks++;
    if (wr_ptr !== 4'd3) begin
      errors++;
      $display("FAIL pre_reset_ptr got %0d expected 3", wr_ptr);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (wr_ptr !== 4'd0 || done !== 1'b0 || bp_ready !== 1'b0 || dut.state !== IDLE) begin
      errors++;
      $display("FAIL mid_fill_reset got wr_ptr=%0d done=%b rdy=%b state=%0d expected 0 0 0 IDLE", wr_ptr, done, bp_ready, dut.state);
    end
    for (int w = 0; w < word_num; w++)
      for (int s = 0; s < 16; s++) push(w, s, 0);
    drain("reset_clear");
    reset = 1'b1;
    tick();
  endtask

  task automatic test_sentence();
    do_start();
    for (int k = 0; k < 4; k++) send(k, 1'b0);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL early_done got %b expected 0", done);
    end
    send(4, 1'b1);
    checks++;
    if (done !== 1'b1 || key_out !== 4'd4 || bp_ready !== 1'b0) begin
      errors++;
      $display("FAIL sentence_end got done=%b key=%0d rdy=%b expected 1 4 0", done, key_out, bp_ready);
    end
    for (int k = 4; k >= 0; k--) push(k, 2, (k + 2) % POS_num);
    push(7, 2, 0);
    drain("traceback");
  endtask

  task automatic test_gaps();
    do_start();
    send(10, 1'b0);
    bp_data = vec(7);
    tick();
    checks++;
    if (wr_ptr !== 4'd1) begin
      errors++;
      $display("FAIL idle_hold got wr_ptr=%0d expected 1", wr_ptr);
    end
    tick();
    send(11, 1'b0);
    checks++;
    if (wr_ptr !== 4'd2) begin
      errors++;
      $display("FAIL gap_ptr got wr_ptr=%0d expected 2", wr_ptr);
    end
    push(0, 3, 2);
    push(1, 3, 3);
    push(1, 10, 10);
    drain("gap_data");
  endtask

  task automatic test_start_priority();
    do_start();
    for (int k = 0; k < 6; k++) send(40 + k, 1'b0);
    checks++;
    if (wr_ptr !== 4'd6) begin
      errors++;
      $display("FAIL prio_setup got wr_ptr=%0d expected 6", wr_ptr);
    end
    start = 1'b1;
    bp_valid = 1'b1;
    bp_data = vec(50);
    tick();
    start = 1'b0;
    bp_valid = 1'b0;
    checks++;
    if (wr_ptr !== 4'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_priority got wr_ptr=%0d done=%b expected 0 0", wr_ptr, done);
    end
    push(6, 1, 0);
    push(5, 1, (45 + 1) % POS_num);
    drain("discard");
  endtask

  task automatic test_overflow();
    do_start();
    for (int k = 0; k < 15; k++) send(20 + k, 1'b0);
    checks++;
    if (overflow !== 1'b0 || done !== 1'b0 || wr_ptr !== 4'd15) begin
      errors++;
      $display("FAIL pre_overflow got ovf=%b done=%b wr_ptr=%0d expected 0 0 15", overflow, done, wr_ptr);
    end
    send(35, 1'b0);
    checks++;
    if (overflow !== 1'b1 || done !== 1'b1 || key_out !== 4'd15 || wr_ptr !== 4'd15 || bp_ready !== 1'b0) begin
      errors++;
      $display("FAIL overflow got ovf=%b done=%b key=%0d wr_ptr=%0d rdy=%b expected 1 1 15 15 0", overflow, done, key_out, wr_ptr, bp_ready);
    end
    send(99, 1'b0);
    checks++;
    if (wr_ptr !== 4'd15 || key_out !== 4'd15 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ignored_17th got wr_ptr=%0d key=%0d ovf=%b expected 15 15 1", wr_ptr, key_out, overflow);
    end
    push(15, 0, 35 % POS_num);
    push(0, 0, 20 % POS_num);
    push(8, 4, 32 % POS_num);
    drain("overflow_data");
  endtask

  task automatic test_done_sweep();
    for (int s = 11; s < 16; s++) push(15, s, 0);
    push(15, 10, 45 % POS_num);
    drain("state_range");
    do_start();
    checks++;
    if (overflow !== 1'b0 || done !== 1'b0 || bp_ready !== 1'b1 || wr_ptr !== 4'd0) begin
      errors++;
      $display("FAIL restart_clear got ovf=%b done=%b rdy=%b wr_ptr=%0d expected 0 0 1 0", overflow, done, bp_ready, wr_ptr);
    end
    push(9, 0, 29 % POS_num);
    drain("stale_kept");
  endtask

  initial begin
    test_reset();
    test_sentence();
    test_gaps();
    test_start_priority();
    test_overflow();
    test_done_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
